// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the MIPS multicycle controller and its datapath.
// master = controller (consumes op/funct/zero, drives enables and selects); slave = datapath.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic       B_sel;
  logic [1:0] RFin_sel;
  logic [1:0] RFout_sel;
  logic [1:0] npcop;
  logic [1:0] extop;
  logic [3:0] aluop;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output PCWr, IRWr, RFWr, DMWr, B_sel, RFin_sel, RFout_sel,
           npcop, extop, aluop, instr_done, illegal
  );

  modport slave (
    output op, funct, zero,
    input  PCWr, IRWr, RFWr, DMWr, B_sel, RFin_sel, RFout_sel,
           npcop, extop, aluop, instr_done, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// MIPS multicycle control FSM; CTRL_ILLEGAL_TRAP_EN makes illegal instructions halt until reset.
// Latency: j/jal/jr/beq 3 cycles, sw/R-type/ori/lui 4, lw 5; outputs registered except the PCWr branch term.
// Backpressure: none; the datapath is assumed to complete every step in one cycle.
module mc_ctrl_fsm (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DCD, S_EXE, S_MEM, S_WB, S_BR, S_JMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;

  state_t state, nxt;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_ralu, is_legal;

  assign is_addu  = (bus.op == OP_RTYPE) && (bus.funct == FN_ADDU);
  assign is_subu  = (bus.op == OP_RTYPE) && (bus.funct == FN_SUBU);
  assign is_jr    = (bus.op == OP_RTYPE) && (bus.funct == FN_JR);
  assign is_ori   = (bus.op == OP_ORI);
  assign is_lui   = (bus.op == OP_LUI);
  assign is_lw    = (bus.op == OP_LW);
  assign is_sw    = (bus.op == OP_SW);
  assign is_beq   = (bus.op == OP_BEQ);
  assign is_j     = (bus.op == OP_J);
  assign is_jal   = (bus.op == OP_JAL);
  assign is_ralu  = is_addu | is_subu;
  assign is_legal = is_ralu | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;

  // ALU-side selects shared by EXE, MEM and WB so operands stay steady through write-back
  logic       exe_b_sel;
  logic [1:0] exe_extop;
  logic [3:0] exe_aluop;

  always_comb begin
    exe_b_sel = 1'b0;
    exe_extop = 2'b00;
    exe_aluop = ALU_ADD;
    if (is_ralu) begin
      exe_aluop = is_subu ? ALU_SUB : ALU_ADD;
    end else if (is_ori) begin
      exe_b_sel = 1'b1;
      exe_aluop = ALU_OR;
    end else if (is_lui) begin
      exe_b_sel = 1'b1;
      exe_extop = 2'b10;
      exe_aluop = ALU_OR;
    end else if (is_lw || is_sw) begin
      exe_b_sel = 1'b1;
      exe_extop = 2'b01;
    end
  end

  logic       pcwr_d, irwr_d, rfwr_d, dmwr_d, b_sel_d, done_d;
  logic [1:0] rfin_d, rfout_d, npcop_d, extop_d;
  logic [3:0] aluop_d;
  logic       pcwr_q, irwr_q, rfwr_q, dmwr_q, b_sel_q, done_q;
  logic [1:0] rfin_q, rfout_q, npcop_q, extop_q;
  logic [3:0] aluop_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_d, illegal_q;
`endif

  always_comb begin
    nxt     = state;
    pcwr_d  = 1'b0;
    irwr_d  = 1'b0;
    rfwr_d  = 1'b0;
    dmwr_d  = 1'b0;
    b_sel_d = 1'b0;
    done_d  = 1'b0;
    rfin_d  = 2'b00;
    rfout_d = 2'b00;
    npcop_d = 2'b00;
    extop_d = 2'b00;
    aluop_d = ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = 1'b0;
`endif

    case (state)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: nxt = S_DCD;
      S_DCD: begin
        if (!is_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          nxt = S_HALT;
`else
          nxt = S_FETCH;
`endif
        end else if (is_beq) begin
          nxt = S_BR;
        end else if (is_j || is_jal || is_jr) begin
          nxt = S_JMP;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE:   nxt = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:   nxt = is_lw ? S_WB : S_FETCH;
      S_WB:    nxt = S_FETCH;
      S_BR:    nxt = S_FETCH;
      S_JMP:   nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase

    // Outputs are decoded for the state being entered, so they hold for its whole cycle
    case (nxt)
      S_FETCH: begin
        irwr_d = 1'b1;
        pcwr_d = 1'b1;
      end
      S_EXE: begin
        b_sel_d = exe_b_sel;
        extop_d = exe_extop;
        aluop_d = exe_aluop;
      end
      S_MEM: begin
        b_sel_d = exe_b_sel;
        extop_d = exe_extop;
        aluop_d = exe_aluop;
        dmwr_d  = is_sw;
        done_d  = is_sw;
      end
      S_WB: begin
        b_sel_d = exe_b_sel;
        extop_d = exe_extop;
        aluop_d = exe_aluop;
        rfwr_d  = 1'b1;
        done_d  = 1'b1;
        rfin_d  = is_lw ? 2'b01 : 2'b00;
        rfout_d = is_ralu ? 2'b01 : 2'b00;
      end
      S_BR: begin
        aluop_d = ALU_SUB;
        extop_d = 2'b01;
        npcop_d = 2'b01;
        done_d  = 1'b1;
      end
      S_JMP: begin
        pcwr_d  = 1'b1;
        done_d  = 1'b1;
        npcop_d = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          rfwr_d  = 1'b1;
          rfin_d  = 2'b10;
          rfout_d = 2'b10;
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:  illegal_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pcwr_q  <= 1'b0;
      irwr_q  <= 1'b0;
      rfwr_q  <= 1'b0;
      dmwr_q  <= 1'b0;
      b_sel_q <= 1'b0;
      done_q  <= 1'b0;
      rfin_q  <= 2'b00;
      rfout_q <= 2'b00;
      npcop_q <= 2'b00;
      extop_q <= 2'b00;
      aluop_q <= 4'b0000;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      pcwr_q  <= pcwr_d;
      irwr_q  <= irwr_d;
      rfwr_q  <= rfwr_d;
      dmwr_q  <= dmwr_d;
      b_sel_q <= b_sel_d;
      done_q  <= done_d;
      rfin_q  <= rfin_d;
      rfout_q <= rfout_d;
      npcop_q <= npcop_d;
      extop_q <= extop_d;
      aluop_q <= aluop_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Branch resolution uses zero from the BR cycle itself, hence the unregistered term
  assign bus.PCWr       = pcwr_q | ((state == S_BR) & bus.zero);
  assign bus.IRWr       = irwr_q;
  assign bus.RFWr       = rfwr_q;
  assign bus.DMWr       = dmwr_q;
  assign bus.B_sel      = b_sel_q;
  assign bus.RFin_sel   = rfin_q;
  assign bus.RFout_sel  = rfout_q;
  assign bus.npcop      = npcop_q;
  assign bus.extop      = extop_q;
  assign bus.aluop      = aluop_q;
  assign bus.instr_done = done_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal    = illegal_q;
`else
  assign bus.illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: random instruction stream checked cycle by cycle against per-instruction
// expected control sequences; also covers reset release, mid-instruction reset and illegal opcodes.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pcwr;
    logic       irwr;
    logic       rfwr;
    logic       dmwr;
    logic       b_sel;
    logic [1:0] rfin;
    logic [1:0] rfout;
    logic [1:0] npc;
    logic [1:0] ext;
    logic [3:0] alu;
    logic       done;
    logic       ill;
  } ctl_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILLOP = 10, K_ILLFN = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();
  mc_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  ctl_t exp_q[$];
  logic zq[$];
  ctl_t got;

  assign got = {bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr, bus.B_sel, bus.RFin_sel,
                bus.RFout_sel, bus.npcop, bus.extop, bus.aluop, bus.instr_done, bus.illegal};

  task automatic check(input string tag, input ctl_t e);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, e);
    end
  endtask

  task automatic enc(input int k, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    o = 6'b000000;
    case (k)
      K_ADDU:  f = 6'b100001;
      K_SUBU:  f = 6'b100011;
      K_JR:    f = 6'b001000;
      K_ILLFN: f = 6'b100000;
      K_ORI:   o = 6'b001101;
      K_LUI:   o = 6'b001111;
      K_LW:    o = 6'b100011;
      K_SW:    o = 6'b101011;
      K_BEQ:   o = 6'b000100;
      K_J:     o = 6'b000010;
      K_JAL:   o = 6'b000011;
      default: o = 6'b111111;
    endcase
  endtask

  task automatic push(input ctl_t c, input logic z);
    exp_q.push_back(c);
    zq.push_back(z);
  endtask

  // Expected controls per cycle of one instruction, straight from the instruction's recipe
  task automatic build(input int k, input logic zbr);
    ctl_t c, s;
    exp_q.delete();
    zq.delete();
    c = '0; c.pcwr = 1'b1; c.irwr = 1'b1;
    push(c, 1'($urandom));
    push('0, 1'($urandom));
    s = '0;
    case (k)
      K_SUBU: s.alu = 4'b0001;
      K_ORI:  begin s.b_sel = 1'b1; s.alu = 4'b0010; end
      K_LUI:  begin s.b_sel = 1'b1; s.ext = 2'b10; s.alu = 4'b0010; end
      K_LW, K_SW: begin s.b_sel = 1'b1; s.ext = 2'b01; end
      default: ;
    endcase
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW: begin
        push(s, 1'($urandom));
        if (k == K_LW || k == K_SW) begin
          c = s;
          if (k == K_SW) begin c.dmwr = 1'b1; c.done = 1'b1; end
          push(c, 1'($urandom));
        end
        if (k != K_SW) begin
          c = s; c.rfwr = 1'b1; c.done = 1'b1;
          c.rfin  = (k == K_LW) ? 2'b01 : 2'b00;
          c.rfout = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
          push(c, 1'($urandom));
        end
      end
      K_BEQ: begin
        c = '0; c.alu = 4'b0001; c.ext = 2'b01; c.npc = 2'b01; c.done = 1'b1; c.pcwr = zbr;
        push(c, zbr);
      end
      K_J, K_JAL, K_JR: begin
        c = '0; c.pcwr = 1'b1; c.done = 1'b1;
        c.npc = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin c.rfwr = 1'b1; c.rfin = 2'b10; c.rfout = 2'b10; end
        push(c, 1'($urandom));
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        c = '0; c.ill = 1'b1;
        for (int i = 0; i < 4; i++) push(c, 1'($urandom));
`endif
      end
    endcase
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1 check("rst_async_clear", '0);
    @(negedge clk);
    check("rst_held", '0);
    rst = 1'b0;
    #1 check("idle_after_rst", '0);
  endtask

  task automatic run(input int k, input logic zbr, input int ncyc);
    logic [5:0] o, f;
    int n;
    build(k, zbr);
    enc(k, o, f);
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        bus.op = o;
        bus.funct = f;
      end
      bus.zero = zq[i];
      @(negedge clk);
      check($sformatf("instr%0d_cyc%0d", k, i), exp_q[i]);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (ncyc < 0 && (k == K_ILLOP || k == K_ILLFN)) do_reset();
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.op = 6'b0;
    bus.funct = 6'b0;
    bus.zero = 1'b1;
    @(negedge clk);
    check("reset_outputs", '0);
    @(negedge clk);
    check("reset_outputs_2", '0);
    rst = 1'b0;
    #1 check("idle_release", '0);

    run(K_ADDU, 1'b0, -1);
    run(K_LW, 1'b0, -1);
    run(K_SW, 1'b0, -1);
    run(K_BEQ, 1'b1, -1);
    run(K_BEQ, 1'b0, -1);
    run(K_JAL, 1'b0, -1);
    run(K_JR, 1'b0, -1);
    run(K_ILLOP, 1'b0, -1);
    run(K_J, 1'b0, -1);
    run(K_SUBU, 1'b0, -1);
    run(K_ORI, 1'b0, -1);
    run(K_LUI, 1'b0, -1);
    run(K_ILLFN, 1'b0, -1);

    // Abort in EXE of ori, and in a taken BR, then restart cleanly
    run(K_ORI, 1'b0, 3);
    do_reset();
    run(K_BEQ, 1'b1, 3);
    do_reset();
    run(K_ADDU, 1'b0, -1);

    for (int r = 0; r < 80; r++) begin
      run(int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle controller that drives the control-signal bundle consumed by the MIPS datapath.
- Decodes op/funct latched in IR and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Generates PC, IR, RF and DM write enables, plus all mux selects and ALU/EXT/NPC mode codes.
- Instantiated inside MIPS between IR outputs and datapath control inputs.

Parameters:
- none.

Ports:
- clk  I  1  clock; all state updates on rising edge
- rst  I  1  asynchronous, active-high reset
- op  I  6  IR[31:26], stable from DECODE until next FETCH
- funct  I  6  IR[5:0]
- zero  I  1  ALU zero flag, combinational from datapath
- PCWr  O  1  PC write enable
- IRWr  O  1  IR write enable
- RFWr  O  1  register-file write enable
- DMWr  O  1  data-memory write enable
- B_sel  O  1  0: rt data, 1: EXT output
- RFin_sel  O  2  00: ALU, 01: DM, 10: PC+4
- RFout_sel  O  2  00: rt, 01: rd, 10: $31
- npcop  O  2  00: PC+4, 01: branch, 10: j/jal target, 11: rs (jr)
- extop  O  2  00: zero-ext, 01: sign-ext, 10: imm<<16
- aluop  O  4  0000 add, 0001 sub, 0010 or
- instr_done  O  1  one-cycle pulse in the last cycle of each instruction
- illegal  O  1  unsupported op/funct flag (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: IDLE. All outputs 0, including selects.
- Registered outputs: every output except PCWr is registered, computed from next state and op/funct, so its value is valid for the whole cycle the FSM is in that state.
- PCWr: PCWr = pcwr_q | (state==BR & zero). The branch decision uses zero in the BR cycle itself.
- Instruction set:
  - R-type (op 000000): addu funct 100001, subu 100011, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States: IDLE, FETCH, DCD, EXE, MEM, WB, BR, JMP, HALT.
- IDLE: unconditionally goes to FETCH the next cycle.
- FETCH: IRWr=1, PCWr=1, npcop=00. Goes to DCD.
- DCD: no write enables asserted. Next state by opcode:
  - R-ALU, ori, lui, lw, sw -> EXE
  - beq -> BR
  - j, jal, jr -> JMP
  - illegal -> FETCH (or HALT with the macro)
- EXE:
  - R-ALU: B_sel=0, aluop add/sub.
  - ori: B_sel=1, extop=00, aluop=or.
  - lui: B_sel=1, extop=10, aluop=or.
  - lw/sw: B_sel=1, extop=01, aluop=add.
  - Next: lw/sw -> MEM, others -> WB.
- MEM:
  - Holds the EXE selects.
  - sw: DMWr=1, instr_done=1, next FETCH.
  - lw: next WB.
- WB:
  - RFWr=1.
  - R-type: RFin_sel=00, RFout_sel=01.
  - ori/lui: RFin_sel=00, RFout_sel=00.
  - lw: RFin_sel=01, RFout_sel=00.
  - Holds the EXE ALU selects. instr_done=1. Next FETCH.
- BR: B_sel=0, aluop=sub, extop=01, npcop=01, instr_done=1, next FETCH. PC is written only if zero=1.
- JMP: PCWr=1 and instr_done=1, then next FETCH.
  - j: npcop=10.
  - jal: npcop=10, plus RFWr=1, RFin_sel=10, RFout_sel=10. The RF write uses the pre-update PC+4 from the datapath.
  - jr: npcop=11.
- Latency (cycles including FETCH): j/jal/jr 3, beq 3, sw 4, R-type/ori/lui 4, lw 5.
- Enable exclusivity: at most one of IRWr, DMWr, RFWr asserted per cycle, except JMP for jal (PCWr+RFWr).
- Reset mid-instruction: returns to IDLE within the same cycle and clears every output asynchronously. No partial write may complete after rst rises.
- op/funct changes outside DCD..end of instruction are ignored.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal op/funct in DCD moves the FSM to HALT. In HALT, illegal=1 and all enables stay 0 until rst.
- Undefined: illegal is tied 0, and an illegal instruction goes DCD -> FETCH with no writes (acts as a 2-cycle NOP).

Test Plan:
- Reset release: IDLE then FETCH. IRWr=1 and PCWr=1 exactly one cycle later; all outputs 0 while rst=1.
- addu (op 000000, funct 100001): DCD, EXE, then WB with RFWr=1, RFout_sel=01, RFin_sel=00, aluop=0000. instr_done after 4 cycles.
- lw then sw:
  - lw takes 5 cycles, WB has RFin_sel=01 and extop=01.
  - sw MEM cycle has DMWr=1 and RFWr=0.
- beq:
  - zero=1 in BR -> PCWr=1, npcop=01.
  - zero=0 -> PCWr=0. Next cycle is FETCH in both cases.
- jal: JMP cycle has PCWr=1, RFWr=1, RFin_sel=10, RFout_sel=10, npcop=10. jr: npcop=11, RFWr=0.
- Illegal op 111111:
  - Without macro: back to FETCH after DCD, no enables, illegal=0.
  - With CTRL_ILLEGAL_TRAP_EN: illegal=1 held until rst.
  - rst asserted mid-EXE clears all outputs immediately.
